tmds_lane_serializer: RTL

//  Parametrised N-channel TMDS symbol serializer that sits between the symbol source and ddr_diff.

---
 rtl/tmds_lane_serializer.sv | 103 ++++++++++
 1 files changed

// File: rtl/tmds_lane_serializer.sv
// N-channel TMDS symbol serializer with a one-symbol holding buffer.
// It emits LANE_W bits per channel per clk_tmds cycle, plus a pixel-clock lane.
module tmds_lane_serializer #(
  parameter int CHANNELS = 3,
  parameter int SYM_W = 10,
  parameter int LANE_W = 2,
  parameter bit MSB_FIRST = 1'b0,
  parameter logic [SYM_W-1:0] IDLE_SYM = 10'b1101010100,
  parameter bit CLK_LANE = 1'b1
) (
  input  logic                         clk_tmds,
  input  logic                         reset,
  input  logic [CHANNELS*SYM_W-1:0]    sym_data,
  input  logic                         sym_valid,
  output logic                         sym_ready,
  input  logic                         clear_underrun,
  output logic [CHANNELS*LANE_W-1:0]   out_data,
  output logic [LANE_W-1:0]            out_clk,
  output logic                         load,
  output logic                         underrun
);

  localparam int PHASES = SYM_W / LANE_W;
  localparam int PH_W = (PHASES > 1) ? $clog2(PHASES) : 1;
  localparam logic [PH_W-1:0] LAST = PH_W'(PHASES - 1);
  localparam logic [SYM_W-1:0] CLK_SYM = CLK_LANE ?
    {{(SYM_W - SYM_W/2){1'b0}}, {(SYM_W/2){1'b1}}} : '0;

  generate
    if ((SYM_W % LANE_W) != 0 || PHASES < 2) begin : g_bad_params
      $error("tmds_lane_serializer: SYM_W must be a multiple of LANE_W with >= 2 phases");
    end
  endgenerate

  logic [PH_W-1:0]            phase;
  logic [CHANNELS*SYM_W-1:0]  hold_q;
  logic                       hold_full;
  logic [SYM_W-1:0]           sh_q [CHANNELS];
  logic [SYM_W-1:0]           clk_q;
  logic                       accept;

  function automatic logic [SYM_W-1:0] shift_sym(input logic [SYM_W-1:0] v);
    if (MSB_FIRST) return v << LANE_W;
    else return v >> LANE_W;
  endfunction

  assign load = (phase == LAST);
  assign sym_ready = !hold_full || load;
  assign accept = sym_valid && sym_ready;

  // Phase counter; reset parks it on the last phase so the first edge loads.
  always_ff @(posedge clk_tmds or posedge reset) begin
    if (reset) phase <= LAST;
    else if (load) phase <= '0;
    else phase <= phase + 1'b1;
  end

  // Holding buffer: refilled on any accept, drained on every load edge.
  always_ff @(posedge clk_tmds or posedge reset) begin
    if (reset) begin
      hold_full <= 1'b0;
      hold_q <= '0;
    end else begin
      if (accept) hold_q <= sym_data;
      if (load) hold_full <= sym_valid;
      else hold_full <= hold_full | sym_valid;
    end
  end

  // Shift registers: reload from buffer (or idle token) on load, else shift.
  always_ff @(posedge clk_tmds or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) sh_q[c] <= '0;
      clk_q <= '0;
    end else if (load) begin
      for (int c = 0; c < CHANNELS; c++)
        sh_q[c] <= hold_full ? hold_q[c*SYM_W +: SYM_W] : IDLE_SYM;
      clk_q <= CLK_SYM;
    end else begin
      for (int c = 0; c < CHANNELS; c++) sh_q[c] <= shift_sym(sh_q[c]);
      clk_q <= shift_sym(clk_q);
    end
  end

  // Sticky underrun; a new underrun beats a same-edge clear.
  always_ff @(posedge clk_tmds or posedge reset) begin
    if (reset) underrun <= 1'b0;
    else if (load && !hold_full) underrun <= 1'b1;
    else if (clear_underrun) underrun <= 1'b0;
  end

  // Output taps straight off the shift registers; bit 0 is the earlier bit.
  always_comb begin
    out_data = '0;
    out_clk = '0;
    for (int j = 0; j < LANE_W; j++) begin
      for (int c = 0; c < CHANNELS; c++)
        out_data[c*LANE_W + j] = MSB_FIRST ? sh_q[c][SYM_W-1-j] : sh_q[c][j];
      out_clk[j] = MSB_FIRST ? clk_q[SYM_W-1-j] : clk_q[j];
    end
  end

endmodule
